// File: rtl/mmio_ctrl_if.sv
// mmio_ctrl_if: CPU memory-bus signals seen by the memory-mapped I/O block.
interface mmio_ctrl_if;
  localparam int unsigned CMD_W  = 2;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 16;

  logic [CMD_W-1:0]  mem_cmd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              io_rd_sel;

  modport master (
    output mem_cmd, mem_addr, write_data,
    input  read_data, io_rd_sel
  );

  modport slave (
    input  mem_cmd, mem_addr, write_data,
    output read_data, io_rd_sel
  );
endinterface

// File: rtl/mmio_ctrl.sv
// mmio_ctrl: memory-mapped I/O block serving the upper half of the CPU address space.
// Provides an LED register, a debounced switch port and a 16-bit cycle timer.
module mmio_ctrl #(
  parameter logic [8:0]  LED_ADDR  = 9'h100,
  parameter logic [8:0]  SW_ADDR   = 9'h140,
  parameter logic [8:0]  TMR_ADDR  = 9'h180,
  parameter logic [8:0]  TCTL_ADDR = 9'h181,
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  mmio_ctrl_if.slave bus,
  input  logic [9:0] SW,
  output logic [7:0] LEDR
);
  localparam int unsigned SW_W  = 10;
  localparam int unsigned LED_W = 8;
  localparam int unsigned TMR_W = 16;
  localparam int unsigned CNT_W = $clog2(DB_CYCLES) + 1;
  localparam logic [1:0]  CMD_WR = 2'b10;
  localparam logic [1:0]  CMD_RD = 2'b01;

  logic             hit_led, hit_sw, hit_tmr, hit_tctl;
  logic             is_wr, is_rd, tctl_wr;
  logic [SW_W-1:0]  sw_s1, sw_s, sw_cand, sw_db;
  logic [CNT_W-1:0] db_cnt;
  logic [TMR_W-1:0] count;
  logic             en, ovf;
  logic             unused_wd;

  // Exact full-address decode
  always_comb begin
    hit_led  = (bus.mem_addr == LED_ADDR);
    hit_sw   = (bus.mem_addr == SW_ADDR);
    hit_tmr  = (bus.mem_addr == TMR_ADDR);
    hit_tctl = (bus.mem_addr == TCTL_ADDR);
    is_wr    = (bus.mem_cmd == CMD_WR);
    is_rd    = (bus.mem_cmd == CMD_RD);
    tctl_wr  = is_wr && hit_tctl;
  end

  assign unused_wd = ^bus.write_data[14:8];

  // Zero-latency read mux; anything that misses returns zero
  always_comb begin
    bus.read_data = '0;
    bus.io_rd_sel = 1'b0;
    if (is_rd) begin
      bus.io_rd_sel = hit_led | hit_sw | hit_tmr | hit_tctl;
      if (hit_led)       bus.read_data = {8'h00, LEDR};
      else if (hit_sw)   bus.read_data = {6'b0, sw_db};
      else if (hit_tmr)  bus.read_data = count;
      else if (hit_tctl) bus.read_data = {ovf, 14'b0, en};
    end
  end

  // LED output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      LEDR <= '0;
    end else if (is_wr && hit_led) begin
      LEDR <= bus.write_data[LED_W-1:0];
    end
  end

  // Switch synchronizer and debounce; sw_cand holds last cycle's sw_s so a
  // change of the candidate value restarts the stability count at one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_s1   <= '0;
      sw_s    <= '0;
      sw_cand <= '0;
      sw_db   <= '0;
      db_cnt  <= '0;
    end else begin
      sw_s1   <= SW;
      sw_s    <= sw_s1;
      sw_cand <= sw_s;
      if (sw_s == sw_db) begin
        db_cnt <= '0;
      end else if (sw_s != sw_cand) begin
        db_cnt <= CNT_W'(1);
      end else if (db_cnt == CNT_W'(DB_CYCLES - 1)) begin
        sw_db  <= sw_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + CNT_W'(1);
      end
    end
  end

  // Cycle timer: clear beats increment, overflow set beats ovf clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      en    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (tctl_wr && bus.write_data[1]) begin
        count <= '0;
      end else if (en) begin
        count <= count + TMR_W'(1);
      end

      if (en && (count == {TMR_W{1'b1}})) begin
        ovf <= 1'b1;
      end else if (tctl_wr && bus.write_data[15]) begin
        ovf <= 1'b0;
      end

      if (tctl_wr) begin
        en <= bus.write_data[0];
      end
    end
  end
endmodule

// File: tb/tb_mmio_ctrl.sv
// tb_mmio_ctrl: directed and randomized checks of mmio_ctrl against a
// register-level behavioural model kept in the bench.
module tb_mmio_ctrl;
  localparam int unsigned DB = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] sw;
  logic [7:0] ledr;
  int         n_tests = 0;
  int         n_fail  = 0;

  mmio_ctrl_if bus ();

  mmio_ctrl #(.DB_CYCLES(DB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .SW    (sw),
    .LEDR  (ledr)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [7:0]  m_led;
  logic [15:0] m_cnt;
  logic        m_en, m_ovf;
  logic [9:0]  m_s1, m_s2, m_db;
  logic [9:0]  m_win[$];

  function automatic void model_reset();
    m_led = '0; m_cnt = '0; m_en = 1'b0; m_ovf = 1'b0;
    m_s1 = '0; m_s2 = '0; m_db = '0;
    m_win.delete();
  endfunction

  // Advance the model across one rising edge using the inputs now applied.
  function automatic void model_edge();
    logic        wr_t;
    logic        all_same;
    logic [15:0] n_cnt;
    logic        n_ovf;
    wr_t = (bus.mem_cmd == 2'b10) && (bus.mem_addr == 9'h181);
    if ((bus.mem_cmd == 2'b10) && (bus.mem_addr == 9'h100)) m_led = bus.write_data[7:0];
    n_cnt = m_en ? m_cnt + 16'd1 : m_cnt;
    if (wr_t && bus.write_data[1]) n_cnt = 16'h0000;
    n_ovf = m_ovf;
    if (wr_t && bus.write_data[15]) n_ovf = 1'b0;
    if (m_en && m_cnt == 16'hFFFF) n_ovf = 1'b1;
    if (wr_t) m_en = bus.write_data[0];
    m_cnt = n_cnt;
    m_ovf = n_ovf;
    // sw_db takes a value once the last DB synchronized samples all agree on it
    m_win.push_back(m_s2);
    if (m_win.size() > DB) void'(m_win.pop_front());
    if (m_win.size() == DB) begin
      all_same = 1'b1;
      foreach (m_win[i]) if (m_win[i] != m_s2) all_same = 1'b0;
      if (all_same && m_s2 != m_db) m_db = m_s2;
    end
    m_s2 = m_s1;
    m_s1 = sw;
  endfunction

  function automatic logic [15:0] model_read(input logic [8:0] a);
    case (a)
      9'h100:  return {8'h00, m_led};
      9'h140:  return {6'b0, m_db};
      9'h180:  return m_cnt;
      9'h181:  return {m_ovf, 14'b0, m_en};
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic model_hit(input logic [8:0] a);
    return (a == 9'h100) || (a == 9'h140) || (a == 9'h180) || (a == 9'h181);
  endfunction

  task automatic cycle(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] wd);
    bus.mem_cmd = cmd; bus.mem_addr = addr; bus.write_data = wd;
    model_edge();
    @(posedge clk); #1;
    bus.mem_cmd = 2'b00; bus.mem_addr = '0; bus.write_data = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(2'b00, 9'h000, 16'h0000);
  endtask

  task automatic probe(input logic [8:0] addr);
    bus.mem_cmd = 2'b01; bus.mem_addr = addr; #1;
  endtask

  task automatic unprobe();
    bus.mem_cmd = 2'b00; bus.mem_addr = '0;
  endtask

  task automatic test_reset();
    logic [8:0] addrs [4] = '{9'h100, 9'h140, 9'h180, 9'h181};
    reset = 1'b0; sw = '0;
    bus.mem_cmd = 2'b00; bus.mem_addr = '0; bus.write_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (ledr !== 8'h00) begin n_fail++; $display("FAIL reset_ledr: got %h expected 00", ledr); end
    n_tests++;
    if (bus.io_rd_sel !== 1'b0 || bus.read_data !== 16'h0000) begin
      n_fail++; $display("FAIL reset_idle_bus: got sel=%b data=%h expected sel=0 data=0000", bus.io_rd_sel, bus.read_data);
    end
    reset = 1'b1;
    foreach (addrs[i]) begin
      probe(addrs[i]);
      n_tests++;
      if (bus.read_data !== 16'h0000 || bus.io_rd_sel !== 1'b1) begin
        n_fail++; $display("FAIL reset_read_%h: got sel=%b data=%h expected sel=1 data=0000", addrs[i], bus.io_rd_sel, bus.read_data);
      end
    end
    unprobe();
    idle(1);
  endtask

  task automatic test_led();
    cycle(2'b10, 9'h100, 16'h12C3);
    n_tests++;
    if (ledr !== 8'hC3) begin n_fail++; $display("FAIL led_write: got %h expected c3", ledr); end
    probe(9'h100);
    n_tests++;
    if (bus.read_data !== 16'h00C3 || bus.io_rd_sel !== 1'b1) begin
      n_fail++; $display("FAIL led_read: got sel=%b data=%h expected sel=1 data=00c3", bus.io_rd_sel, bus.read_data);
    end
    unprobe();
    cycle(2'b10, 9'h102, 16'hFFFF);
    n_tests++;
    if (ledr !== 8'hC3) begin n_fail++; $display("FAIL led_unmapped_write: got %h expected c3", ledr); end
    probe(9'h102);
    n_tests++;
    if (bus.read_data !== 16'h0000 || bus.io_rd_sel !== 1'b0) begin
      n_fail++; $display("FAIL unmapped_read: got sel=%b data=%h expected sel=0 data=0000", bus.io_rd_sel, bus.read_data);
    end
    unprobe();
    cycle(2'b10, 9'h140, 16'h03FF);
    cycle(2'b10, 9'h180, 16'h5555);
    probe(9'h140);
    n_tests++;
    if (bus.read_data !== model_read(9'h140)) begin
      n_fail++; $display("FAIL sw_write_ignored: got %h expected %h", bus.read_data, model_read(9'h140));
    end
    probe(9'h180);
    n_tests++;
    if (bus.read_data !== model_read(9'h180)) begin
      n_fail++; $display("FAIL tmr_write_ignored: got %h expected %h", bus.read_data, model_read(9'h180));
    end
    unprobe();
  endtask

  task automatic test_ram_space();
    probe(9'h080);
    n_tests++;
    if (bus.read_data !== 16'h0000 || bus.io_rd_sel !== 1'b0) begin
      n_fail++; $display("FAIL ram_read: got sel=%b data=%h expected sel=0 data=0000", bus.io_rd_sel, bus.read_data);
    end
    cycle(2'b01, 9'h080, 16'h0000);
    cycle(2'b10, 9'h000, 16'h00FF);
    n_tests++;
    if (ledr !== m_led) begin n_fail++; $display("FAIL ram_write_no_effect: got %h expected %h", ledr, m_led); end
  endtask

  task automatic test_switch();
    logic [15:0] exp;
    sw = 10'h2AA;
    for (int k = 1; k <= 20; k++) begin
      idle(1);
      probe(9'h140);
      exp = (k < 18) ? 16'h0000 : 16'h02AA;
      n_tests++;
      if (bus.read_data !== exp || bus.io_rd_sel !== 1'b1) begin
        n_fail++; $display("FAIL sw_debounce_cycle%0d: got %h expected %h", k, bus.read_data, exp);
      end
      unprobe();
    end
  endtask

  task automatic test_switch_glitch();
    sw = 10'h155;
    for (int k = 0; k < 30; k++) begin
      if (k == 5) sw = 10'h2AA;
      idle(1);
      probe(9'h140);
      n_tests++;
      if (bus.read_data !== 16'h02AA) begin
        n_fail++; $display("FAIL sw_glitch_cycle%0d: got %h expected 02aa", k, bus.read_data);
      end
      unprobe();
    end
  endtask

  task automatic test_timer();
    cycle(2'b10, 9'h181, 16'h0002);
    cycle(2'b10, 9'h181, 16'h0001);
    for (int k = 1; k <= 10; k++) begin
      idle(1);
      probe(9'h180);
      n_tests++;
      if (bus.read_data !== 16'(k)) begin
        n_fail++; $display("FAIL timer_count_%0d: got %h expected %h", k, bus.read_data, 16'(k));
      end
      unprobe();
    end
    cycle(2'b10, 9'h181, 16'h0003);
    probe(9'h180);
    n_tests++;
    if (bus.read_data !== 16'h0000) begin n_fail++; $display("FAIL timer_clear: got %h expected 0000", bus.read_data); end
    unprobe();
    idle(1);
    probe(9'h180);
    n_tests++;
    if (bus.read_data !== 16'h0001) begin n_fail++; $display("FAIL timer_after_clear: got %h expected 0001", bus.read_data); end
    unprobe();
  endtask

  task automatic test_timer_wrap();
    logic [15:0] frozen;
    for (int g = 0; g < 70000 && m_cnt != 16'hFFFF; g++) idle(1);
    probe(9'h180);
    n_tests++;
    if (bus.read_data !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_pre_count: got %h expected ffff", bus.read_data); end
    probe(9'h181);
    n_tests++;
    if (bus.read_data !== 16'h0001) begin n_fail++; $display("FAIL wrap_pre_ctl: got %h expected 0001", bus.read_data); end
    unprobe();
    // ovf clear written on the very edge that wraps: the set must win
    cycle(2'b10, 9'h181, 16'h8001);
    probe(9'h180);
    n_tests++;
    if (bus.read_data !== 16'h0000) begin n_fail++; $display("FAIL wrap_count: got %h expected 0000", bus.read_data); end
    probe(9'h181);
    n_tests++;
    if (bus.read_data !== 16'h8001) begin n_fail++; $display("FAIL wrap_ovf_set_wins: got %h expected 8001", bus.read_data); end
    unprobe();
    idle(5);
    probe(9'h181);
    n_tests++;
    if (bus.read_data !== 16'h8001) begin n_fail++; $display("FAIL ovf_sticky: got %h expected 8001", bus.read_data); end
    unprobe();
    cycle(2'b10, 9'h181, 16'h8001);
    probe(9'h181);
    n_tests++;
    if (bus.read_data !== 16'h0001) begin n_fail++; $display("FAIL ovf_clear: got %h expected 0001", bus.read_data); end
    unprobe();
    cycle(2'b10, 9'h181, 16'h8000);
    probe(9'h181);
    n_tests++;
    if (bus.read_data !== 16'h0000) begin n_fail++; $display("FAIL timer_disable: got %h expected 0000", bus.read_data); end
    probe(9'h180);
    frozen = bus.read_data;
    unprobe();
    idle(3);
    probe(9'h180);
    n_tests++;
    if (bus.read_data !== frozen || bus.read_data !== m_cnt) begin
      n_fail++; $display("FAIL timer_frozen: got %h expected %h", bus.read_data, m_cnt);
    end
    unprobe();
  endtask

  task automatic test_random();
    logic [8:0] addrs [8] = '{9'h100, 9'h140, 9'h180, 9'h181, 9'h102, 9'h080, 9'h1FF, 9'h000};
    logic [8:0] a;
    int         hold = 0;
    for (int i = 0; i < 400; i++) begin
      if (hold == 0) begin
        sw = 10'($urandom);
        hold = int'($urandom_range(30, 1));
      end else begin
        hold--;
      end
      a = addrs[$urandom_range(7, 0)];
      probe(a);
      n_tests++;
      if (bus.read_data !== model_read(a) || bus.io_rd_sel !== model_hit(a)) begin
        n_fail++; $display("FAIL random_read_%0d addr %h: got sel=%b data=%h expected sel=%b data=%h",
                           i, a, bus.io_rd_sel, bus.read_data, model_hit(a), model_read(a));
      end
      n_tests++;
      if (ledr !== m_led) begin n_fail++; $display("FAIL random_ledr_%0d: got %h expected %h", i, ledr, m_led); end
      case ($urandom_range(2, 0))
        0:       cycle(2'b10, a, 16'($urandom));
        1:       cycle(2'b01, a, 16'h0000);
        default: cycle(2'b00, 9'($urandom), 16'($urandom));
      endcase
    end
  endtask

  task automatic test_reset_midrun();
    logic [8:0] addrs [4] = '{9'h100, 9'h140, 9'h180, 9'h181};
    sw = 10'h000;
    cycle(2'b10, 9'h100, 16'h00A5);
    cycle(2'b10, 9'h181, 16'h0003);
    for (int g = 0; g < 1000 && m_cnt != 16'h0123; g++) idle(1);
    probe(9'h180);
    n_tests++;
    if (bus.read_data !== 16'h0123 || ledr !== 8'hA5) begin
      n_fail++; $display("FAIL pre_reset_state: got cnt=%h led=%h expected cnt=0123 led=a5", bus.read_data, ledr);
    end
    unprobe();
    reset = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (ledr !== 8'h00) begin n_fail++; $display("FAIL midrun_reset_ledr: got %h expected 00", ledr); end
    foreach (addrs[i]) begin
      probe(addrs[i]);
      n_tests++;
      if (bus.read_data !== 16'h0000) begin
        n_fail++; $display("FAIL midrun_reset_read_%h: got %h expected 0000", addrs[i], bus.read_data);
      end
    end
    // a write presented while reset is held must not land
    bus.mem_cmd = 2'b10; bus.mem_addr = 9'h100; bus.write_data = 16'h00FF;
    @(posedge clk); #1;
    n_tests++;
    if (ledr !== 8'h00) begin n_fail++; $display("FAIL write_during_reset: got %h expected 00", ledr); end
    unprobe();
    bus.write_data = '0;
    reset = 1'b1;
    idle(2);
    probe(9'h180);
    n_tests++;
    if (bus.read_data !== 16'h0000 || ledr !== 8'h00) begin
      n_fail++; $display("FAIL post_reset_state: got cnt=%h led=%h expected cnt=0000 led=00", bus.read_data, ledr);
    end
    unprobe();
  endtask

  initial begin
    test_reset();
    test_led();
    test_ram_space();
    test_switch();
    test_switch_glitch();
    test_timer();
    test_timer_wrap();
    test_random();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end
endmodule
